// File: rtl/lock_key_pkg.sv
// Shared types and constants for the serial key loader of a logic-locked netlist.
package lock_key_pkg;

  localparam int          KEY_W_DEF    = 6;
  localparam logic [7:0]  SYNC_DEF     = 8'hA5;
  localparam int          GAP_MAX_DEF  = 16;
  localparam int          MAX_FAIL_DEF = 3;

  // Key field positions in key_out: mux selects p1..p4, then the two XOR keys.
  localparam int P1_IDX = 0;
  localparam int P2_IDX = 1;
  localparam int P3_IDX = 2;
  localparam int P4_IDX = 3;
  localparam int X1_IDX = 4;
  localparam int X2_IDX = 5;

  typedef enum logic [2:0] {
    HUNT,
    KEY,
    PARITY,
    APPLY,
    LOCKOUT
  } state_e;

  function automatic logic state_takes_bits(input state_e s);
    return (s == HUNT) || (s == KEY) || (s == PARITY);
  endfunction

endpackage

// File: rtl/gap_timer.sv
// Counts idle cycles between accepted frame bits; expire marks the GAP_MAX-th idle cycle.
module gap_timer #(
  parameter int GAP_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int CW = $clog2(GAP_MAX + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en || clr)
      cnt <= '0;
    else if (cnt != CW'(GAP_MAX))
      cnt <= cnt + 1'b1;
  end

  // An accepted bit in the same cycle always beats the timeout.
  assign expire = en && !clr && (cnt == CW'(GAP_MAX - 1));

endmodule

// File: rtl/lock_key_loader.sv
// Hunts for a sync byte, shifts in a key plus even parity, and applies the key atomically.
module lock_key_loader
  import lock_key_pkg::*;
#(
  parameter int         KEY_W     = KEY_W_DEF,
  parameter logic [7:0] SYNC_WORD = SYNC_DEF,
  parameter int         GAP_MAX   = GAP_MAX_DEF,
  parameter int         MAX_FAIL  = MAX_FAIL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic             s_data,
  output logic             s_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             err,
  output logic             locked_out
);

  localparam int BCW = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam int FCW = $clog2(MAX_FAIL + 1);

  state_e           state, state_n;
  logic [BCW-1:0]   bit_cnt, bit_cnt_n;
  logic [7:0]       window, window_n, win_shift;
  logic [KEY_W-1:0] shadow, shadow_n;
  logic [FCW-1:0]   fail_cnt;
  logic             acc, expire, fail, do_apply, timer_en;

  assign acc       = s_valid && s_ready;
  assign timer_en  = (state == KEY) || (state == PARITY);
  assign win_shift = {window[6:0], s_data};

  gap_timer #(.GAP_MAX(GAP_MAX)) u_gap (
    .clk    (clk),
    .rst    (rst),
    .en     (timer_en),
    .clr    (acc),
    .expire (expire)
  );

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    window_n  = window;
    shadow_n  = shadow;
    fail      = 1'b0;
    do_apply  = 1'b0;
    case (state)
      HUNT: begin
        if (acc) begin
          if (win_shift == SYNC_WORD) begin
            state_n   = KEY;
            bit_cnt_n = '0;
            window_n  = '0;
          end else begin
            window_n = win_shift;
          end
        end
      end
      KEY: begin
        if (acc) begin
          shadow_n[bit_cnt] = s_data;
          bit_cnt_n         = bit_cnt + 1'b1;
          if (bit_cnt == BCW'(KEY_W - 1))
            state_n = PARITY;
        end else if (expire) begin
          fail = 1'b1;
        end
      end
      PARITY: begin
        if (acc) begin
          if (^{shadow, s_data})
            fail = 1'b1;
          else
            state_n = APPLY;
        end else if (expire) begin
          fail = 1'b1;
        end
      end
      APPLY: begin
        do_apply = 1'b1;
        state_n  = HUNT;
      end
      LOCKOUT: state_n = LOCKOUT;
      default: state_n = HUNT;
    endcase
    // A failed frame drops any partial key; the failure that hits the limit locks us out.
    if (fail) begin
      shadow_n  = '0;
      bit_cnt_n = '0;
      state_n   = (fail_cnt >= FCW'(MAX_FAIL - 1)) ? LOCKOUT : HUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      bit_cnt    <= '0;
      window     <= '0;
      shadow     <= '0;
      fail_cnt   <= '0;
      s_ready    <= 1'b0;
      key_out    <= '0;
      key_valid  <= 1'b0;
      err        <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      window  <= window_n;
      shadow  <= shadow_n;
      s_ready <= state_takes_bits(state_n);
      err     <= fail;
      if (fail && (fail_cnt != FCW'(MAX_FAIL)))
        fail_cnt <= fail_cnt + 1'b1;
      if (state_n == LOCKOUT) begin
        key_out    <= '0;
        key_valid  <= 1'b0;
        locked_out <= 1'b1;
      end else if (do_apply) begin
        key_out   <= shadow;
        key_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lock_key_loader.sv
// Randomized frames plus directed scenarios, checked cycle by cycle against a frame-level model.
module tb_lock_key_loader;

  localparam int KW  = 6;
  localparam int GAP = 16;
  localparam int MF  = 3;

  logic          clk = 1'b0;
  logic          rst, s_valid, s_data;
  logic          s_ready, key_valid, err, locked_out;
  logic [KW-1:0] key_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lock_key_loader #(.KEY_W(KW), .SYNC_WORD(8'hA5), .GAP_MAX(GAP), .MAX_FAIL(MF)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .err        (err),
    .locked_out (locked_out)
  );

  // Reference model: sync history byte, queue of frame bits, idle count, fail count.
  bit          m_ready, m_err, m_kv, m_lock, m_pend, m_inframe;
  bit [KW-1:0] m_key, m_pkey;
  bit [7:0]    m_hist;
  bit          m_q[$];
  int          m_idle, m_fails;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_fail();
    m_err     = 1'b1;
    m_inframe = 1'b0;
    if (m_fails < MF) m_fails++;
    if (m_fails == MF) begin
      m_lock = 1'b1;
      m_key  = '0;
      m_kv   = 1'b0;
    end
  endtask

  task automatic model_step(input bit v, input bit d, input bit r);
    bit acc;
    int ones;
    if (r) begin
      m_ready = 0; m_err = 0; m_kv = 0; m_lock = 0; m_pend = 0; m_inframe = 0;
      m_key = '0; m_hist = '0; m_q.delete(); m_idle = 0; m_fails = 0;
      return;
    end
    acc   = v && m_ready;
    m_err = 1'b0;
    if (m_lock) begin
      m_ready = 1'b0;
      return;
    end
    if (m_pend) begin
      m_key  = m_pkey;
      m_kv   = 1'b1;
      m_pend = 1'b0;
    end else if (!m_inframe) begin
      if (acc) begin
        m_hist = {m_hist[6:0], d};
        if (m_hist == 8'hA5) begin
          m_inframe = 1'b1;
          m_q.delete();
          m_idle = 0;
          m_hist = '0;
        end
      end
    end else if (acc) begin
      m_q.push_back(d);
      m_idle = 0;
      if (m_q.size() == KW + 1) begin
        ones = 0;
        foreach (m_q[i]) ones += int'(m_q[i]);
        m_inframe = 1'b0;
        if (ones % 2 == 0) begin
          m_pend = 1'b1;
          for (int i = 0; i < KW; i++) m_pkey[i] = m_q[i];
        end else begin
          model_fail();
        end
      end
    end else begin
      m_idle++;
      if (m_idle == GAP) model_fail();
    end
    m_ready = !m_lock && !m_pend;
  endtask

  task automatic step(input bit v, input bit d, input bit r);
    s_valid = v;
    s_data  = d;
    rst     = r;
    @(posedge clk);
    model_step(v, d, r);
    #1;
    chk("s_ready",    32'(s_ready),    32'(m_ready));
    chk("key_out",    32'(key_out),    32'(m_key));
    chk("key_valid",  32'(key_valid),  32'(m_kv));
    chk("err",        32'(err),        32'(m_err));
    chk("locked_out", 32'(locked_out), 32'(m_lock));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bit(input bit d);
    int tries = 0;
    while (!m_ready && tries < 4) begin
      step(1'b0, 1'b0, 1'b0);
      tries++;
    end
    step(1'b1, d, 1'b0);
  endtask

  task automatic send_byte(input bit [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_frame(input bit [KW-1:0] k, input bit bad);
    send_byte(8'hA5);
    for (int i = 0; i < KW; i++) send_bit(k[i]);
    send_bit((^k) ^ bad);
  endtask

  initial begin
    bit [KW-1:0] rk;
    s_valid = 1'b0;
    s_data  = 1'b0;
    rst     = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_key",   32'(key_out), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("ready_rise", 32'(s_ready), 32'd1);

    // Nominal load: key 1,0,1,1,0,1 LSB first, parity 0.
    send_frame(6'b101101, 1'b0);
    chk("nom_before", 32'(key_valid), 32'd0);
    idle(1);
    chk("nom_key", 32'(key_out), 32'h2D);
    chk("nom_kv",  32'(key_valid), 32'd1);

    // Parity error keeps the previous key.
    send_frame(6'b010010, 1'b1);
    chk("par_err", 32'(err), 32'd1);
    idle(1);
    chk("par_key", 32'(key_out), 32'h2D);

    // Leading junk before the sync byte.
    send_bit(1'b1);
    send_bit(1'b1);
    send_frame(6'b000011, 1'b0);
    idle(2);
    chk("hunt_key", 32'(key_out), 32'h03);

    // Gap timeout after three key bits, then a clean frame.
    send_byte(8'hA5);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    idle(15);
    chk("gap_early", 32'(err), 32'd0);
    idle(1);
    chk("gap_err", 32'(err), 32'd1);
    send_frame(6'b110000, 1'b0);
    idle(2);
    chk("gap_key", 32'(key_out), 32'h30);

    // Reset mid-frame, then a fresh frame.
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("mid_rst_key", 32'(key_out), 32'd0);
    chk("mid_rst_kv",  32'(key_valid), 32'd0);
    send_frame(6'b011100, 1'b0);
    idle(2);
    chk("mid_rst_reload", 32'(key_out), 32'h1C);

    // Three bad frames lock the loader; a good frame afterwards is ignored.
    for (int i = 0; i < 3; i++) send_frame(6'b100001, 1'b1);
    idle(1);
    chk("lock_flag",  32'(locked_out), 32'd1);
    chk("lock_ready", 32'(s_ready), 32'd0);
    chk("lock_key",   32'(key_out), 32'd0);
    send_frame(6'b101101, 1'b0);
    idle(2);
    chk("lock_hold", 32'(key_valid), 32'd0);
    step(1'b0, 1'b0, 1'b1);

    // Random frames with junk, gaps, occasional bad parity and long stalls.
    for (int f = 0; f < 200; f++) begin
      if (m_lock) step(1'b0, 1'b0, 1'b1);
      for (int j = $urandom_range(0, 3); j > 0; j--) send_bit(1'($urandom));
      send_byte(8'hA5);
      rk = KW'($urandom);
      for (int i = 0; i <= KW; i++) begin
        if ($urandom_range(0, 39) == 0) idle($urandom_range(GAP - 1, GAP + 2));
        else idle($urandom_range(0, 2));
        if (i < KW) send_bit(rk[i]);
        else send_bit((^rk) ^ ($urandom_range(0, 5) == 0));
      end
      idle($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
